gobang_eval_sched: RTL



---
 rtl/gobang_eval_sched.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/gobang_eval_sched.sv
// rtl/gobang_eval_sched.sv - scores one candidate move by driving the form judge over four directions
// Optional defense pass (colour-swapped repeat of all four directions) enabled by GOBANG_EVAL_DEFENSE_EN.
module gobang_eval_sched #(
  parameter int BOARD_N = 15,
  parameter int ADDR_W  = 8,
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         pos_row,
  input  logic [3:0]         pos_col,
  input  logic               player,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic               win,
  output logic               occupied,
  output logic [11:0]        dir_types,
  output logic               board_rd,
  output logic [ADDR_W-1:0]  board_addr,
  input  logic [1:0]         board_data,
  output logic [8:0]         judge_a,
  output logic [8:0]         judge_b,
  input  logic [2:0]         judge_type
);

  typedef enum logic [2:0] {IDLE, CTR_RD, CTR_CHK, FETCH, DRAIN, JUDGE, DONE} state_t;

  state_t       state;
  logic [3:0]   row_q, col_q, k_q, pend_k;
  logic         player_q, pass_q, pend_v;
  logic [1:0]   dir_q;
  logic [8:0]   a_mask, b_mask, a_next, b_next;
  logic [1:0]   own;
  logic [3:0]   k_inc;
  logic         last_pass;
  logic [SCORE_W:0] sum;

  // Returns {on_board, address} for window index k of direction d around (r0, c0).
  function automatic logic [ADDR_W:0] cell_of(input logic [1:0] d, input logic [3:0] k,
                                               input logic [3:0] r0, input logic [3:0] c0);
    logic [ADDR_W:0] res;
    int off, dr, dc, r, c;
    off = int'(k) - 4;
    case (d)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    r = int'(r0) + dr * off;
    c = int'(c0) + dc * off;
    res[ADDR_W] = (r >= 0) && (r < BOARD_N) && (c >= 0) && (c < BOARD_N);
    res[ADDR_W-1:0] = ADDR_W'(r * BOARD_N + c);
    return res;
  endfunction

  function automatic logic [15:0] weight_of(input logic [2:0] t);
    case (t)
      3'd0:    return 16'd0;
      3'd1:    return 16'd10;
      3'd2:    return 16'd50;
      3'd3:    return 16'd100;
      3'd4:    return 16'd500;
      3'd5:    return 16'd1000;
      3'd6:    return 16'd5000;
      default: return 16'd50000;
    endcase
  endfunction

`ifdef GOBANG_EVAL_DEFENSE_EN
  assign last_pass = pass_q;
`else
  assign last_pass = 1'b1;
`endif

  // The defense pass simply swaps which colour counts as own.
  assign own   = (player_q ^ pass_q) ? 2'b10 : 2'b01;
  assign k_inc = (k_q == 4'd3) ? 4'd5 : k_q + 4'd1;
  assign sum   = {1'b0, score} + {{(SCORE_W-15){1'b0}}, weight_of(judge_type)};

  // Masks with the read returned this cycle merged in.
  always_comb begin
    a_next = a_mask;
    b_next = b_mask;
    if (pend_v) begin
      if (board_data == own)
        a_next[pend_k] = 1'b1;
      else if (board_data != 2'b00)
        b_next[pend_k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      score      <= '0;
      win        <= 1'b0;
      occupied   <= 1'b0;
      dir_types  <= '0;
      board_rd   <= 1'b0;
      board_addr <= '0;
      judge_a    <= '0;
      judge_b    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      player_q   <= 1'b0;
      pass_q     <= 1'b0;
      dir_q      <= '0;
      k_q        <= '0;
      a_mask     <= '0;
      b_mask     <= '0;
      pend_v     <= 1'b0;
      pend_k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            row_q      <= pos_row;
            col_q      <= pos_col;
            player_q   <= player;
            pass_q     <= 1'b0;
            score      <= '0;
            win        <= 1'b0;
            occupied   <= 1'b0;
            dir_types  <= '0;
            board_rd   <= 1'b1;
            board_addr <= ADDR_W'(int'(pos_row) * BOARD_N + int'(pos_col));
            state      <= CTR_RD;
          end
        end
        CTR_RD: begin
          board_rd <= 1'b0;
          state    <= CTR_CHK;
        end
        CTR_CHK: begin
          if (board_data != 2'b00) begin
            occupied <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            dir_q                  <= 2'd0;
            k_q                    <= 4'd0;
            a_mask                 <= '0;
            b_mask                 <= '0;
            pend_v                 <= 1'b0;
            {board_rd, board_addr} <= cell_of(2'd0, 4'd0, row_q, col_q);
            state                  <= FETCH;
          end
        end
        FETCH: begin
          a_mask <= a_next;
          b_mask <= b_next;
          // No read means the cell is off the board, which blocks like an opponent stone.
          if (!board_rd)
            b_mask[k_q] <= 1'b1;
          pend_v <= board_rd;
          pend_k <= k_q;
          if (k_q == 4'd8) begin
            board_rd <= 1'b0;
            state    <= DRAIN;
          end else begin
            k_q                    <= k_inc;
            {board_rd, board_addr} <= cell_of(dir_q, k_inc, row_q, col_q);
          end
        end
        DRAIN: begin
          pend_v  <= 1'b0;
          judge_a <= a_next | 9'h010;
          judge_b <= b_next & 9'h1EF;
          state   <= JUDGE;
        end
        JUDGE: begin
          score <= sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
          if (!pass_q) begin
            dir_types[3*dir_q +: 3] <= judge_type;
            if (judge_type == 3'd7)
              win <= 1'b1;
          end
          if (dir_q == 2'd3 && last_pass) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (dir_q == 2'd3)
              pass_q <= 1'b1;
            dir_q                  <= dir_q + 2'd1;
            k_q                    <= 4'd0;
            a_mask                 <= '0;
            b_mask                 <= '0;
            {board_rd, board_addr} <= cell_of(dir_q + 2'd1, 4'd0, row_q, col_q);
            state                  <= FETCH;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
